// File: rtl/uart_tx_hamming13.sv
// UART transmitter: Hamming SECDED-13 encodes a byte and sends it as two 8N1 bytes (HI, idle gap, LO).
// Latency 1 cycle from accepted tx_start to start bit; no backpressure, tx_start is ignored while busy.
module uart_tx_hamming13 #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE, START_BIT, DATA_BITS, STOP_BIT, GAP, CLEANUP
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, bit_nxt;
  logic        sel_lo, sel_lo_nxt;
  logic [12:0] code, code_nxt;
  logic        serial_nxt, busy_nxt, done_nxt;
  logic        bit_end;
  logic [7:0]  cur_byte;

  // code[i-1] holds Hamming position i; code[12] is overall parity
  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] c;
    c      = '0;
    c[2]   = d[0];
    c[4]   = d[1];
    c[5]   = d[2];
    c[6]   = d[3];
    c[8]   = d[4];
    c[9]   = d[5];
    c[10]  = d[6];
    c[11]  = d[7];
    c[0]   = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[1]   = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[3]   = c[4] ^ c[5] ^ c[6] ^ c[11];
    c[7]   = c[8] ^ c[9] ^ c[10] ^ c[11];
    c[12]  = ^c[11:0];
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sel_lo    <= 1'b0;
      code      <= '0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      sel_lo    <= sel_lo_nxt;
      code      <= code_nxt;
      tx_serial <= serial_nxt;
      tx_busy   <= busy_nxt;
      tx_done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_idx;
    sel_lo_nxt = sel_lo;
    code_nxt   = code;
    bit_end    = (cnt == LAST_CNT);
    case (state)
      IDLE: begin
        if (tx_start) begin
          state_nxt  = START_BIT;
          code_nxt   = encode(data_in);
          sel_lo_nxt = 1'b0;
          cnt_nxt    = '0;
          bit_nxt    = '0;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = DATA_BITS;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            bit_nxt   = '0;
            state_nxt = STOP_BIT;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = sel_lo ? CLEANUP : GAP;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      GAP: begin
        if (bit_end) begin
          cnt_nxt    = '0;
          sel_lo_nxt = 1'b1;
          state_nxt  = START_BIT;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      CLEANUP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight out of flops
    cur_byte   = sel_lo_nxt ? {code_nxt[4:0], 3'b000} : code_nxt[12:5];
    serial_nxt = 1'b1;
    case (state_nxt)
      START_BIT: serial_nxt = 1'b0;
      DATA_BITS: serial_nxt = cur_byte[3'd7 - bit_nxt];
      default:   serial_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == CLEANUP);
  end

endmodule

// File: doc/uart_tx_hamming13.md
UART_TX_HAMMING13 -- requirements
Module: uart_tx_hamming13

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, giving the clock cycles per serial bit period (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge clocked.
REQ-003 SHALL have port rst, input, 1, reset; synchronous to clk and active-high.
REQ-004 SHALL have port tx_start, input, 1, request to send data_in (level-sampled, one-cycle pulse expected).
REQ-005 SHALL have port data_in, input, 8, the data byte to encode and send.
REQ-006 SHALL have port tx_serial, output, 1, the serial line; idle level is 1.
REQ-007 SHALL have port tx_busy, output, 1, high while a frame is in progress.
REQ-008 SHALL have port tx_done, output, 1, one-cycle pulse at frame completion.

Function
REQ-009 SHALL encode data_in into a 13-bit Hamming SECDED codeword code[12:0] that matches hamming13_decoder; code[i-1] is Hamming position i for i = 1..12.
REQ-010 SHALL place parity bits at positions 1, 2, 4 and 8, and data d[0..7] at positions 3, 5, 6, 7, 9, 10, 11 and 12 respectively.
REQ-011 SHALL set each parity bit as even parity over its covered positions:
- p1 covers 3, 5, 7, 9, 11.
- p2 covers 3, 6, 7, 10, 11.
- p4 covers 5, 6, 7, 12.
- p8 covers 9, 10, 11, 12.
REQ-012 SHALL set code[12] to the XOR of code[11:0], giving even overall parity.
REQ-013 SHALL transmit two bytes per request:
- HI = code[12:5].
- LO = {code[4:0], 3'b000}.
REQ-014 SHALL send each byte as 8N1: start bit 0, 8 data bits MSB first (bit 7 first), stop bit 1.
REQ-015 SHALL hold each bit on tx_serial for exactly CLKS_PER_BIT cycles, counted by an internal counter of at least 16 bits.
REQ-016 SHALL insert one idle bit period (tx_serial = 1, CLKS_PER_BIT cycles) between the HI stop bit and the LO start bit.
REQ-017 SHALL therefore make a frame last 21*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the LO stop bit.
REQ-018 SHALL implement the states IDLE, START_BIT, DATA_BITS, STOP_BIT, GAP and CLEANUP, plus a byte-select flag.
REQ-019 SHALL follow this transition sequence:
- IDLE to START_BIT on tx_start = 1.
- START_BIT to DATA_BITS after one bit period.
- DATA_BITS to STOP_BIT after 8 bit periods.
- STOP_BIT to GAP when the byte-select flag = HI.
- GAP to START_BIT after one bit period, with byte-select set to LO.
- STOP_BIT to CLEANUP when byte-select = LO.
- CLEANUP to IDLE after one cycle.
REQ-020 SHALL register data_in (or its codeword) at the clk edge where tx_start = 1 is sampled in IDLE; later changes to data_in SHALL NOT affect the frame.
REQ-021 SHALL drive tx_serial = 0 starting in the cycle after the accepting edge; this is a latency of 1 cycle.
REQ-022 SHALL drive tx_busy = 1 in every state except IDLE, including CLEANUP.
REQ-023 SHALL assert tx_done = 1 only during the single CLEANUP cycle, immediately after the LO stop bit ends.
REQ-024 SHALL ignore tx_start while the state is not IDLE, including during CLEANUP; no queuing of requests.
REQ-025 SHALL accept a tx_start that is held high in the first IDLE cycle after CLEANUP; this allows back-to-back frames with a 2-cycle high gap.
REQ-026 SHALL keep tx_serial = 1 in IDLE, STOP_BIT, GAP and CLEANUP.
REQ-027 SHALL drive all outputs from registers; tx_serial SHALL be glitch-free.

Reset
REQ-028 SHALL, on rst = 1 at a clk edge, force state = IDLE, tx_serial = 1, tx_busy = 0, tx_done = 0, all counters = 0 and byte-select = HI.
REQ-029 SHALL, on rst asserted mid-frame, abort the frame at that edge with no partial tx_done, and set tx_serial = 1 from the next cycle.
REQ-030 SHALL give rst priority over a simultaneous tx_start; the request is dropped.

Verification
REQ-031 Scenario 1: CLKS_PER_BIT=8, data_in=0x01 -> codeword 0x1007; wire carries HI=0x80 and LO=0x38; tx_done pulses 168 cycles after tx_serial first falls.
REQ-032 Scenario 2: data_in=0xFF -> codeword 0x0F77; HI=0x7B and LO=0xB8; the uart_rx_hamming13 loopback reports data_out=0xFF, single_error=0 and double_error=0.
REQ-033 Scenario 3: data_in=0x00 -> HI=0x00, LO=0x00; the GAP bit is sampled high at mid-bit; the receiver loopback gives 0x00.
REQ-034 Scenario 4: tx_start pulsed again at cycle 50 of a frame with data_in=0x55 -> ignored; exactly one tx_done; original byte delivered.
REQ-035 Scenario 5: rst asserted during HI DATA_BITS -> tx_serial=1 and tx_busy=0 next cycle; no tx_done; a new tx_start afterwards sends a full correct frame.
REQ-036 Scenario 6: all 256 data values through tx, with a single injected bit flip per frame, into uart_rx_hamming13 -> data corrected and single_error=1; a double flip gives double_error=1.
